// File: rtl/led_light_pkg.sv
// Shared types and sizes for the led_light design.
package led_light_pkg;
  localparam int LED_N = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    SHIFT_L = 2'd0,
    SHIFT_R = 2'd1,
    BOUNCE  = 2'd2,
    BLINK   = 2'd3
  } led_mode_t;
endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with a fixed compare: duty_on is high for the
// first TRAIL_DUTY clocks of every 2**PWM_BITS-clock period.
module pwm_gen #(
  parameter int PWM_BITS   = 4,
  parameter int TRAIL_DUTY = 4
) (
  input  logic clock,
  input  logic reset,
  output logic duty_on
);
  localparam logic [PWM_BITS:0]   DUTY    = (PWM_BITS + 1)'(TRAIL_DUTY);
  localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] pwm_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_q + CNT_ONE;
  end

  assign duty_on = ({1'b0, pwm_cnt_q} < DUTY);
endmodule

// File: rtl/led_chaser_ctrl.sv
// LED chase controller: turns upstream count steps into a one-hot chase with a
// PWM-dimmed trail, in one of four modes that only change at a frame wrap.
module led_chaser_ctrl
  import led_light_pkg::*;
#(
  parameter int PWM_BITS   = 4,
  parameter int TRAIL_DUTY = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       mode_req,
  input  logic             mode_valid,
  output logic             mode_ack,
  output logic [LED_N-1:0] led,
  output logic             frame_done
);
  localparam logic [CNT_W-1:0] POS_MAX = CNT_W'(LED_N - 1);
  localparam logic [CNT_W-1:0] POS_ONE = CNT_W'(1);

  led_mode_t        mode_q, mode_d, pending_mode_q, pending_mode_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] prev_count_q;
  logic [CNT_W-1:0] pos_q, pos_d, trail_pos_q, trail_pos_d;
  logic             dir_down_q, dir_down_d;
  logic             trail_en_q, trail_en_d;
  logic             blink_phase_q, blink_phase_d;
  logic [LED_N-1:0] led_q, led_d;
  logic             mode_ack_q, frame_done_q;
  logic             step, wrap, capture, apply, duty_on;

  pwm_gen #(
    .PWM_BITS  (PWM_BITS),
    .TRAIL_DUTY(TRAIL_DUTY)
  ) u_pwm (
    .clock  (clock),
    .reset  (reset),
    .duty_on(duty_on)
  );

  // Any change of count is one step, however far it jumps; only 7->0 is a wrap.
  assign step    = (count != prev_count_q);
  assign wrap    = step && (prev_count_q == POS_MAX) && (count == '0);
  assign capture = mode_valid && !mode_ack_q;
  assign apply   = wrap && pending_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pending_mode_d = capture ? led_mode_t'(mode_req) : pending_mode_q;
    pending_d      = (pending_q || capture) && !apply;
    mode_d         = mode_q;
    pos_d          = pos_q;
    dir_down_d     = dir_down_q;
    trail_pos_d    = trail_pos_q;
    trail_en_d     = trail_en_q;
    blink_phase_d  = blink_phase_q;

    if (step) begin
      if (apply) begin
        mode_d        = pending_mode_d;
        pos_d         = '0;
        dir_down_d    = 1'b0;
        trail_en_d    = 1'b0;
        blink_phase_d = 1'b0;
      end else begin
        trail_pos_d = pos_q;
        trail_en_d  = (mode_q != BLINK);
        if (wrap) blink_phase_d = !blink_phase_q;
        if (mode_q == BOUNCE) begin
          if (dir_down_q) begin
            pos_d = pos_q - POS_ONE;
            if (pos_d == '0) dir_down_d = 1'b0;
          end else begin
            pos_d = pos_q + POS_ONE;
            if (pos_d == POS_MAX) dir_down_d = 1'b1;
          end
        end
      end
      // Keyed on the next mode so the wrap that switches modes renders in the new one.
      case (mode_d)
        SHIFT_L: pos_d = count;
        SHIFT_R: pos_d = POS_MAX - count;
        default: ;
      endcase
    end

    led_d = '0;
    if (mode_d == BLINK) begin
      led_d = {LED_N{blink_phase_d}};
    end else begin
      if (trail_en_d) led_d[trail_pos_d] = duty_on;
      led_d[pos_d] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q         <= SHIFT_L;
      pending_mode_q <= SHIFT_L;
      pending_q      <= 1'b0;
      prev_count_q   <= '0;
      pos_q          <= '0;
      dir_down_q     <= 1'b0;
      trail_pos_q    <= '0;
      trail_en_q     <= 1'b0;
      blink_phase_q  <= 1'b0;
      led_q          <= '0;
      mode_ack_q     <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      pending_mode_q <= pending_mode_d;
      pending_q      <= pending_d;
      prev_count_q   <= count;
      pos_q          <= pos_d;
      dir_down_q     <= dir_down_d;
      trail_pos_q    <= trail_pos_d;
      trail_en_q     <= trail_en_d;
      blink_phase_q  <= blink_phase_d;
      led_q          <= led_d;
      mode_ack_q     <= apply;
      frame_done_q   <= wrap;
    end
  end

  assign led        = led_q;
  assign mode_ack   = mode_ack_q;
  assign frame_done = frame_done_q;
endmodule
